// File: rtl/enemy_draw_sequencer.sv
// Purpose: grants the shared VGA write port to each live enemy engine in ascending index order.
// Latency: grant two cycles after draw is first sampled high; pixel path is one register stage.
// Backpressure: none; a stalled engine loses its grant after TIMEOUT cycles and timeout_err is raised.
module enemy_draw_sequencer #(
    parameter int N_ENEMIES = 3,
    parameter int IDX_W     = 2,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int COLOUR_W  = 6,
    parameter int TIMEOUT   = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          draw,
    input  logic [N_ENEMIES-1:0]          alive,
    input  logic [N_ENEMIES*X_W-1:0]      src_x_draw,
    input  logic [N_ENEMIES*Y_W-1:0]      src_y_draw,
    input  logic [N_ENEMIES*COLOUR_W-1:0] src_colour,
    input  logic [N_ENEMIES-1:0]          src_write,
    input  logic [N_ENEMIES-1:0]          src_done,
    output logic [N_ENEMIES-1:0]          draw_en,
    output logic [X_W-1:0]                x_draw,
    output logic [Y_W-1:0]                y_draw,
    output logic [COLOUR_W-1:0]           colour,
    output logic                          VGA_write,
    output logic [IDX_W-1:0]              cur_index,
    output logic                          draw_done,
    output logic                          timeout_err
);

    // Timer counts 0..TIMEOUT-1 while an enemy holds the grant.
    localparam int              TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_DRAW,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_ENEMIES-1:0]  r_pend;
    logic [N_ENEMIES-1:0]  w_pend_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [IDX_W-1:0]      w_low_idx;
    logic [TMR_W-1:0]      r_timer;
    logic [TMR_W-1:0]      w_timer_nxt;
    logic                  r_timeout_err;
    logic                  w_timeout_err_nxt;
    logic                  w_abort;
    logic                  w_timeout_hit;

    // Selected source (the engine addressed by r_idx).
    logic [N_ENEMIES-1:0]  w_grant;
    logic [X_W-1:0]        w_sel_x;
    logic [Y_W-1:0]        w_sel_y;
    logic [COLOUR_W-1:0]   w_sel_colour;
    logic                  w_sel_write;
    logic                  w_sel_done;

    // Registered pixel stage.
    logic [X_W-1:0]        r_x;
    logic [Y_W-1:0]        r_y;
    logic [COLOUR_W-1:0]   r_colour;
    logic                  r_vga_write;

    // Dropping draw outside IDLE abandons the frame immediately.
    assign w_abort       = (r_state != S_IDLE) && !draw;
    assign w_timeout_hit = (r_timer == TMR_LAST);

    // Lowest pending enemy; scanning downward lets the lowest set bit win.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_ENEMIES - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    // Mux the granted engine's stream and decode the one-hot grant.
    always_comb begin
        w_grant      = '0;
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        w_sel_write  = 1'b0;
        w_sel_done   = 1'b0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_grant[i]   = (r_state == S_DRAW);
                w_sel_x      = src_x_draw[i*X_W +: X_W];
                w_sel_y      = src_y_draw[i*Y_W +: Y_W];
                w_sel_colour = src_colour[i*COLOUR_W +: COLOUR_W];
                w_sel_write  = src_write[i];
                w_sel_done   = src_done[i];
            end
        end
    end

    // Next-state logic for the grant sequencer and its bookkeeping.
    always_comb begin
        w_state_nxt       = r_state;
        w_pend_nxt        = r_pend;
        w_idx_nxt         = r_idx;
        w_timer_nxt       = r_timer;
        w_timeout_err_nxt = r_timeout_err;

        case (r_state)
            S_IDLE: begin
                if (draw) begin
                    // alive is sampled once per frame; later changes are ignored.
                    w_pend_nxt        = alive;
                    w_timeout_err_nxt = 1'b0;
                    w_state_nxt       = (alive == '0) ? S_DONE : S_GRANT;
                end
            end
            S_GRANT: begin
                w_idx_nxt   = w_low_idx;
                w_timer_nxt = '0;
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                // Saturating so a long TIMEOUT never wraps back to zero.
                if (r_timer != TMR_MAX) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
                if (w_sel_done || w_timeout_hit) begin
                    w_pend_nxt  = r_pend & ~w_grant;
                    w_state_nxt = S_RELEASE;
                    if (!w_sel_done) begin
                        w_timeout_err_nxt = 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                // One dead cycle between grants so the engines see a clean handover.
                w_state_nxt = (r_pend != '0) ? S_GRANT : S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything except the sticky error flag.
        if (w_abort) begin
            w_state_nxt       = S_IDLE;
            w_pend_nxt        = '0;
            w_idx_nxt         = '0;
            w_timer_nxt       = '0;
            w_timeout_err_nxt = r_timeout_err;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pend        <= '0;
            r_idx         <= '0;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend        <= w_pend_nxt;
            r_idx         <= w_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    // Pixel register stage: capture the granted stream, suppress a pixel that arrives with done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_colour    <= '0;
            r_vga_write <= 1'b0;
        end else if (w_abort) begin
            r_x         <= '0;
            r_y         <= '0;
            r_colour    <= '0;
            r_vga_write <= 1'b0;
        end else if (r_state == S_DRAW) begin
            r_x         <= w_sel_x;
            r_y         <= w_sel_y;
            r_colour    <= w_sel_colour;
            r_vga_write <= w_sel_write & ~w_sel_done;
        end else begin
            r_vga_write <= 1'b0;
        end
    end

    // Moore outputs decoded from the sequencer state.
    always_comb begin
        cur_index = '0;
        if ((r_state == S_GRANT) || (r_state == S_DRAW) || (r_state == S_RELEASE)) begin
            cur_index = r_idx;
        end
    end

    assign draw_en     = w_grant;
    assign draw_done   = (r_state == S_DONE);
    assign timeout_err = r_timeout_err;
    assign x_draw      = r_x;
    assign y_draw      = r_y;
    assign colour      = r_colour;
    assign VGA_write   = r_vga_write;

endmodule

// File: tb/tb_enemy_draw_sequencer.sv
// Purpose: directed bench for enemy_draw_sequencer with a behavioural engine model and pixel scoreboard.
// Latency: pixels expected one cycle after the engine presents them.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_enemy_draw_sequencer;

    localparam int N    = 3;
    localparam int IW   = 2;
    localparam int X_W  = 9;
    localparam int Y_W  = 8;
    localparam int C_W  = 6;
    localparam int TMO  = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic               draw;
    logic [N-1:0]       alive;
    logic [N*X_W-1:0]   src_x_draw;
    logic [N*Y_W-1:0]   src_y_draw;
    logic [N*C_W-1:0]   src_colour;
    logic [N-1:0]       src_write;
    logic [N-1:0]       src_done;
    logic [N-1:0]       draw_en;
    logic [X_W-1:0]     x_draw;
    logic [Y_W-1:0]     y_draw;
    logic [C_W-1:0]     colour;
    logic               VGA_write;
    logic [IW-1:0]      cur_index;
    logic               draw_done;
    logic               timeout_err;

    enemy_draw_sequencer #(
        .N_ENEMIES(N), .IDX_W(IW), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .draw(draw), .alive(alive),
        .src_x_draw(src_x_draw), .src_y_draw(src_y_draw), .src_colour(src_colour),
        .src_write(src_write), .src_done(src_done), .draw_en(draw_en),
        .x_draw(x_draw), .y_draw(y_draw), .colour(colour), .VGA_write(VGA_write),
        .cur_index(cur_index), .draw_done(draw_done), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Engine model configuration and state.
    int cnt[N];
    int npix[N];
    bit stuck[N];
    bit dwp[N];
    bit tog;

    // Scoreboard: pixel the engine presented last cycle.
    bit             pv;
    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;
    logic [C_W-1:0] pc;

    // Per-frame statistics.
    int           frame_cyc;
    int           pulses;
    int           en_len[N];
    int           gap;
    bit           started;
    logic [N-1:0] prev_en;
    int           grant_seq[$];
    int           gaps[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: check last cycle's pixel, record grant stats, drive the engines for this cycle.
    task automatic step();
        logic [N-1:0] en;
        @(posedge clock);
        #1;
        frame_cyc++;
        chk("vga_write", VGA_write, pv);
        if (pv) begin
            chk("x_draw", x_draw, px);
            chk("y_draw", y_draw, py);
            chk("colour", colour, pc);
        end
        if (VGA_write) pulses++;
        en = draw_en;
        if (en == '0) begin
            if (prev_en != '0) begin
                started = 1'b1;
                gap     = 0;
            end
            gap++;
        end else if (prev_en == '0) begin
            grant_seq.push_back(int'(cur_index));
            if (started) gaps.push_back(gap);
        end
        for (int i = 0; i < N; i++) if (en[i]) en_len[i]++;
        prev_en = en;

        pv         = 1'b0;
        tog        = ~tog;
        src_x_draw = '1;
        src_y_draw = '1;
        src_colour = '1;
        src_write  = '0;
        src_done   = '0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                if (cnt[i] < npix[i]) begin
                    px = X_W'(i * 100 + cnt[i]);
                    py = Y_W'(i * 10 + cnt[i]);
                    pc = C_W'(i * 8 + cnt[i]);
                    src_x_draw[i*X_W +: X_W] = px;
                    src_y_draw[i*Y_W +: Y_W] = py;
                    src_colour[i*C_W +: C_W] = pc;
                    src_write[i] = 1'b1;
                    pv = 1'b1;
                    cnt[i]++;
                    if (dwp[i] && cnt[i] == npix[i]) begin
                        src_done[i] = 1'b1;
                        pv = 1'b0;
                    end
                end else if (!stuck[i]) begin
                    src_done[i] = 1'b1;
                end
            end else begin
                src_write[i] = tog;
            end
        end
    endtask

    task automatic new_frame(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) begin
            cnt[i]    = 0;
            en_len[i] = 0;
        end
        frame_cyc = 0;
        pulses    = 0;
        gap       = 0;
        started   = 1'b0;
        prev_en   = '0;
        grant_seq.delete();
        gaps.delete();
        alive = a;
        draw  = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        while (!draw_done && frame_cyc < budget) step();
        if (!draw_done) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic end_frame();
        draw = 1'b0;
        step();
        chk("done_drop", draw_done, 1'b0);
        step();
    endtask

    task automatic cfg(input int n0, input int n1, input int n2);
        npix[0] = n0; npix[1] = n1; npix[2] = n2;
        for (int i = 0; i < N; i++) begin
            stuck[i] = 1'b0;
            dwp[i]   = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0; draw = 1'b0; alive = '0; tog = 1'b0; pv = 1'b0;
        src_x_draw = '0; src_y_draw = '0; src_colour = '0; src_write = '0; src_done = '0;
        px = '0; py = '0; pc = '0;
        cfg(4, 4, 4);
        #2;
        chk("rst_draw_en", draw_en, 3'b000);
        chk("rst_vga", VGA_write, 1'b0);
        chk("rst_done", draw_done, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        chk("rst_x", x_draw, 9'd0);
        chk("rst_cidx", cur_index, 2'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        step();

        // Full frame, all three alive, four pixels each.
        new_frame(3'b111);
        step();
        chk("f1_grant_wait", draw_en, 3'b000);
        step();
        chk("f1_grant0", draw_en, 3'b001);
        wait_done("f1_done_wait", 100);
        chk("f1_done_cycle", frame_cyc, 22);
        chk("f1_pulses", pulses, 12);
        chk("f1_ngrant", grant_seq.size(), 3);
        if (grant_seq.size() == 3) begin
            chk("f1_order0", grant_seq[0], 0);
            chk("f1_order1", grant_seq[1], 1);
            chk("f1_order2", grant_seq[2], 2);
        end
        chk("f1_ngap", gaps.size(), 2);
        if (gaps.size() == 2) begin
            chk("f1_gap0", gaps[0], 2);
            chk("f1_gap1", gaps[1], 2);
        end
        for (int i = 0; i < N; i++) chk("f1_en_len", en_len[i], 5);
        step(); step(); step();
        chk("f1_done_held", draw_done, 1'b1);
        end_frame();

        // Enemy 1 dead; enemy 2's last pixel arrives together with done.
        cfg(3, 4, 2);
        dwp[2] = 1'b1;
        new_frame(3'b101);
        wait_done("f2_done_wait", 100);
        chk("f2_done_cycle", frame_cyc, 11);
        chk("f2_pulses", pulses, 4);
        chk("f2_en1_len", en_len[1], 0);
        chk("f2_ngrant", grant_seq.size(), 2);
        if (grant_seq.size() == 2) begin
            chk("f2_cidx0", grant_seq[0], 0);
            chk("f2_cidx1", grant_seq[1], 2);
        end
        end_frame();

        // No enemies alive.
        cfg(4, 4, 4);
        new_frame(3'b000);
        step(); step();
        chk("f3_done", draw_done, 1'b1);
        chk("f3_pulses", pulses, 0);
        chk("f3_cidx", cur_index, 2'd0);
        end_frame();

        // Enemy 1 never finishes: timeout after exactly TMO granted cycles.
        cfg(2, 2, 2);
        stuck[1] = 1'b1;
        new_frame(3'b111);
        wait_done("f4_done_wait", 100);
        chk("f4_done_cycle", frame_cyc, 21);
        chk("f4_en1_len", en_len[1], TMO);
        chk("f4_en2_len", en_len[2], 3);
        chk("f4_pulses", pulses, 6);
        chk("f4_terr", timeout_err, 1'b1);
        end_frame();
        chk("f4_terr_sticky", timeout_err, 1'b1);
        cfg(1, 1, 1);
        new_frame(3'b111);
        step();
        chk("f5_terr_clr", timeout_err, 1'b0);
        wait_done("f5_done_wait", 100);
        chk("f5_terr_end", timeout_err, 1'b0);
        end_frame();

        // Abort partway through enemy 1, then restart.
        cfg(6, 6, 6);
        new_frame(3'b111);
        while (!draw_en[1] && frame_cyc < 60) step();
        chk("f6_reach_e1", draw_en[1], 1'b1);
        step(); step();
        draw = 1'b0;
        pv   = 1'b0;
        step();
        chk("f6_abort_en", draw_en, 3'b000);
        chk("f6_abort_cidx", cur_index, 2'd0);
        chk("f6_abort_x", x_draw, 9'd0);
        chk("f6_abort_done", draw_done, 1'b0);
        step();
        cfg(1, 1, 1);
        new_frame(3'b111);
        step(); step();
        chk("f7_restart_en", draw_en, 3'b001);
        chk("f7_restart_cidx", cur_index, 2'd0);
        wait_done("f7_done_wait", 100);
        end_frame();

        // Asynchronous reset in the middle of a grant.
        cfg(4, 4, 4);
        new_frame(3'b111);
        step(); step(); step(); step();
        chk("f8_in_draw", draw_en, 3'b001);
        #2;
        reset = 1'b0;
        #1;
        chk("ares_en", draw_en, 3'b000);
        chk("ares_vga", VGA_write, 1'b0);
        chk("ares_x", x_draw, 9'd0);
        chk("ares_y", y_draw, 8'd0);
        chk("ares_col", colour, 6'd0);
        chk("ares_cidx", cur_index, 2'd0);
        draw = 1'b0;
        pv   = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        step();
        chk("ares_idle_done", draw_done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
